// File: rtl/ib_v2c_dispatch.sv
// ib_v2c_dispatch: v2c source select (VNU vs channel LLR), word FIFO
// toward the check-node side, per-layer transfer counter with done pulse.
module ib_v2c_dispatch #(
    parameter int QUAN_SIZE      = 4,
    parameter int PIPELINE_DEPTH = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int MSG_PER_LAYER  = 5
) (
    input  logic                 read_clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 vnu_valid,
    output logic                 vnu_ready,
    input  logic [QUAN_SIZE-1:0] M0,
    input  logic [QUAN_SIZE-1:0] M1,
    input  logic [QUAN_SIZE-1:0] M2,
    input  logic [QUAN_SIZE-1:0] ch_llr_in,
    input  logic                 v2c_src,
    output logic                 v2c_valid,
    input  logic                 v2c_ready,
    output logic [QUAN_SIZE-1:0] v2c_msg0,
    output logic [QUAN_SIZE-1:0] v2c_msg1,
    output logic [QUAN_SIZE-1:0] v2c_msg2,
    output logic                 layer_done,
    output logic                 overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int MW = 3 * QUAN_SIZE;
    localparam int LW = $clog2(MSG_PER_LAYER + 1);
    localparam int AL = PIPELINE_DEPTH - 1;

    logic [QUAN_SIZE-1:0] al_q [AL];
    logic [QUAN_SIZE-1:0] ch_llr_al;

    logic [MW-1:0] mem [FIFO_DEPTH];
    logic [MW-1:0] word;
    logic [MW-1:0] rd_data;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [LW-1:0] msg_cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          last;

    // Channel LLR delayed to line up with the VNU outputs.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < AL; i++) begin
                al_q[i] <= '0;
            end
        end else begin
            al_q[0] <= ch_llr_in;
            for (int i = 1; i < AL; i++) begin
                al_q[i] <= al_q[i-1];
            end
        end
    end

    assign ch_llr_al = al_q[AL-1];

    assign word = v2c_src ? {3{ch_llr_al}} : {M0, M1, M2};

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign vnu_ready = !full;
    assign v2c_valid = !empty;
    assign push      = vnu_valid && vnu_ready;
    assign pop       = v2c_valid && v2c_ready;
    assign last      = (msg_cnt == LW'(MSG_PER_LAYER - 1));

    always_ff @(posedge read_clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (vnu_valid && full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            msg_cnt    <= '0;
            layer_done <= 1'b0;
        end else if (flush) begin
            msg_cnt    <= '0;
            layer_done <= 1'b0;
        end else if (pop) begin
            msg_cnt    <= last ? '0 : msg_cnt + LW'(1);
            layer_done <= last;
        end else begin
            layer_done <= 1'b0;
        end
    end

    // Gate with valid so the unreset memory never leaks X to the outputs.
    assign rd_data  = v2c_valid ? mem[rd_ptr] : '0;
    assign v2c_msg0 = rd_data[MW-1 -: QUAN_SIZE];
    assign v2c_msg1 = rd_data[MW-1-QUAN_SIZE -: QUAN_SIZE];
    assign v2c_msg2 = rd_data[QUAN_SIZE-1:0];

endmodule
